// File: rtl/ram_loader_pkg.sv
// Shared definitions for the byte loader that feeds the 8x8 byte register bank.
// Contents: FSM state encoding, bytes per word, lane index width, checksum width.
package ram_loader_pkg;

   localparam int NUM_BYTES = 8;
   localparam int IDX_W     = 3;
   localparam int CHK_W     = 8;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_COMMIT = 2'd1,
      ST_HOLD   = 2'd2
   } loader_state_t;

endpackage

// File: rtl/ram_byte_loader_if.sv
// Byte stream handshake into the loader.
//   s_data   8  input byte
//   s_valid  1  s_data valid
//   s_ready  1  loader can accept; transfer when s_valid && s_ready
interface ram_byte_loader_if;

   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/ram_loader_chk.sv
// Running XOR of accepted bytes for the word being assembled.
// Ports:
//   w_clk  in   clock
//   rst_n  in   synchronous active-low reset
//   clr    in   clear accumulator (has priority over en)
//   en     in   fold d into the accumulator
//   d      in   byte to fold in
//   chk    out  accumulated XOR
module ram_loader_chk
   import ram_loader_pkg::*;
(
   input  logic             w_clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CHK_W-1:0] d,
   output logic [CHK_W-1:0] chk
);

   always_ff @(posedge w_clk) begin
      if (!rst_n) begin
         chk <= '0;
      end else if (clr) begin
         chk <= '0;
      end else if (en) begin
         chk <= chk ^ d;
      end
   end

endmodule

// File: rtl/ram_byte_loader.sv
// Feeds the 8x8 byte bank: assembles 8 streamed bytes into one 64-bit word by
// driving din/w_addr, flags completion and stalls the stream until word_ack.
// The bank writes din into lane w_addr[2:0] on every clock edge, so din/w_addr
// change only on an accepted byte and hold otherwise.
// Ports:
//   w_clk       in   clock shared with the bank
//   rst_n       in   synchronous active-low reset
//   s_bus       if   byte stream (slave side)
//   flush       in   abort the partial/pending word
//   din         out  byte to bank (registered)
//   w_addr      out  bank lane {0, idx} (registered)
//   word_valid  out  bank holds a complete word, level until word_ack
//   word_ack    in   consumer has taken the word
//   word_cnt    out  completed words since reset, wraps
//   chk_out     out  XOR of the word's bytes
// Build option: LOADER_CHECKSUM_EN enables the checksum; otherwise chk_out = 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FILL    | accepting bytes, s_ready=1
// COMMIT  | byte 7 on din, bank captures it at the edge leaving COMMIT
// HOLD    | word complete, word_valid=1, waiting for word_ack
module ram_byte_loader
   import ram_loader_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic                 w_clk,
   input  logic                 rst_n,
   ram_byte_loader_if.slave     s_bus,
   input  logic                 flush,
   output logic [7:0]           din,
   output logic [ADDR_W-1:0]    w_addr,
   output logic                 word_valid,
   input  logic                 word_ack,
   output logic [CNT_W-1:0]     word_cnt,
   output logic [CHK_W-1:0]     chk_out
);

   loader_state_t    state;
   logic [IDX_W-1:0] idx;
   logic             accept;

   assign s_bus.s_ready = (state == ST_FILL);
   // flush wins over a byte offered in the same cycle
   assign accept = s_bus.s_valid && s_bus.s_ready && !flush;

   always_ff @(posedge w_clk) begin
      if (!rst_n) begin
         state      <= ST_FILL;
         idx        <= '0;
         din        <= '0;
         w_addr     <= '0;
         word_valid <= 1'b0;
         word_cnt   <= '0;
      end else if (flush) begin
         state      <= ST_FILL;
         idx        <= '0;
         word_valid <= 1'b0;
      end else begin
         case (state)
            ST_FILL: begin
               if (s_bus.s_valid) begin
                  din    <= s_bus.s_data;
                  w_addr <= {{(ADDR_W-IDX_W){1'b0}}, idx};
                  idx    <= idx + 1'b1;
                  if (idx == IDX_W'(NUM_BYTES-1))
                     state <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               word_valid <= 1'b1;
               word_cnt   <= word_cnt + 1'b1;
               state      <= ST_HOLD;
            end
            ST_HOLD: begin
               if (word_ack) begin
                  word_valid <= 1'b0;
                  idx        <= '0;
                  state      <= ST_FILL;
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   ram_loader_chk u_chk (
      .w_clk (w_clk),
      .rst_n (rst_n),
      .clr   (flush || ((state == ST_HOLD) && word_ack)),
      .en    (accept),
      .d     (s_bus.s_data),
      .chk   (chk_out)
   );
`else
   assign chk_out = '0;
`endif

endmodule

// File: tb/tb_ram_byte_loader.sv
// Bench for ram_byte_loader: models the byte bank, keeps a word-level reference
// model and checks every cycle plus directed and randomized scenarios.
module tb_ram_byte_loader;

   logic        w_clk = 1'b0;
   logic        rst_n, flush, word_ack;
   logic [7:0]  din;
   logic [3:0]  w_addr;
   logic        word_valid;
   logic [15:0] word_cnt;
   logic [7:0]  chk_out;

   always #5 w_clk = ~w_clk;

   ram_byte_loader_if s_bus ();

   ram_byte_loader dut (
      .w_clk      (w_clk),
      .rst_n      (rst_n),
      .s_bus      (s_bus),
      .flush      (flush),
      .din        (din),
      .w_addr     (w_addr),
      .word_valid (word_valid),
      .word_ack   (word_ack),
      .word_cnt   (word_cnt),
      .chk_out    (chk_out)
   );

   // bank: no write strobe, writes every edge
   logic [7:0] bank [8];
   always @(posedge w_clk) bank[w_addr[2:0]] <= din;

   function automatic logic [63:0] bank_word();
      logic [63:0] w;
      for (int i = 0; i < 8; i++) w[i*8 +: 8] = bank[i];
      return w;
   endfunction

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: bytes collected so far, word-complete flag
   int          m_cnt = 0;
   logic        m_valid = 1'b0;
   logic [7:0]  m_din = 8'h00;
   logic [3:0]  m_addr = 4'h0;
   logic [15:0] m_wcnt = 16'h0;
   logic [7:0]  m_chk = 8'h00;
   logic [7:0]  m_bytes [8];

   task automatic tick();
      logic        rose;
      logic [63:0] w;
      rose = 1'b0;
      if (rst_n === 1'b1) check("s_ready", s_bus.s_ready, m_cnt < 8);
      if (!rst_n) begin
         m_cnt = 0; m_valid = 0; m_din = 0; m_addr = 0; m_wcnt = 0; m_chk = 0;
      end else if (flush) begin
         m_cnt = 0; m_valid = 0; m_chk = 0;
      end else if (m_cnt < 8) begin
         if (s_bus.s_valid) begin
            m_din = s_bus.s_data;
            m_addr = 4'(m_cnt);
            m_bytes[m_cnt] = s_bus.s_data;
            m_chk ^= s_bus.s_data;
            m_cnt++;
         end
      end else if (!m_valid) begin
         m_valid = 1'b1;
         m_wcnt++;
         rose = 1'b1;
      end else if (word_ack) begin
         m_valid = 1'b0; m_cnt = 0; m_chk = 0;
      end
      @(posedge w_clk);
      #1;
      check("din", din, m_din);
      check("w_addr", w_addr, m_addr);
      check("word_valid", word_valid, m_valid);
      check("word_cnt", word_cnt, m_wcnt);
      if (rose) begin
         for (int i = 0; i < 8; i++) w[i*8 +: 8] = m_bytes[i];
         check("word", bank_word(), w);
      end
      if (m_valid) begin
`ifdef LOADER_CHECKSUM_EN
         check("chk_out", chk_out, m_chk);
`else
         check("chk_out", chk_out, 8'h00);
`endif
      end
   endtask

   task automatic send(input logic [7:0] b);
      s_bus.s_valid = 1'b1;
      s_bus.s_data  = b;
      tick();
      s_bus.s_valid = 1'b0;
   endtask

   task automatic ack();
      word_ack = 1'b1;
      tick();
      word_ack = 1'b0;
   endtask

   int words, cycles, hold, delay;
   logic [15:0] cnt0;
   logic        ackd;

   initial begin
      rst_n = 1'b0; flush = 1'b0; word_ack = 1'b0;
      s_bus.s_valid = 1'b0; s_bus.s_data = 8'h00;
      tick(); tick();
      check("rst_din", din, 8'h00);
      check("rst_valid", word_valid, 1'b0);
      check("rst_cnt", word_cnt, 16'h0);
      check("rst_ready", s_bus.s_ready, 1'b1);
      rst_n = 1'b1;

      // 1 / 6: bytes 01..08 back-to-back
      for (int i = 0; i < 8; i++) begin
         s_bus.s_valid = 1'b1;
         s_bus.s_data  = 8'(i + 1);
         tick();
      end
      s_bus.s_valid = 1'b0;
      check("t1_valid_early", word_valid, 1'b0);
      tick();
      check("t1_word", bank_word(), 64'h0807060504030201);
      check("t1_valid", word_valid, 1'b1);
      check("t1_ready", s_bus.s_ready, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      check("t6_chk", chk_out, 8'h08);
`else
      check("t6_chk", chk_out, 8'h00);
`endif

      // 2: stream offered during HOLD, then ack
      for (int i = 0; i < 5; i++) begin
         s_bus.s_valid = 1'b1;
         s_bus.s_data  = 8'($urandom);
         tick();
      end
      s_bus.s_valid = 1'b0;
      check("t2_word_held", bank_word(), 64'h0807060504030201);
      ack();
      check("t2_valid", word_valid, 1'b0);
      check("t2_ready", s_bus.s_ready, 1'b1);
      check("t2_cnt", word_cnt, 16'd1);

      // 3: partial word, flush with a byte offered, then A0..A7
      send(8'h11); send(8'h22); send(8'h33);
      flush = 1'b1;
      send(8'hEE);
      flush = 1'b0;
      check("t3_addr_hold", w_addr, 4'd2);
      for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
      tick();
      check("t3_word", bank_word(), 64'hA7A6A5A4A3A2A1A0);
      check("t3_cnt", word_cnt, 16'd2);
      ack();

      // 5: reset after 4 bytes
      for (int i = 0; i < 4; i++) send(8'(8'h50 + i));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t5_din", din, 8'h00);
      check("t5_addr", w_addr, 4'h0);
      check("t5_valid", word_valid, 1'b0);
      check("t5_cnt", word_cnt, 16'd0);
      for (int i = 0; i < 8; i++) send(8'(8'hC0 + i));
      tick();
      check("t5_word", bank_word(), 64'hC7C6C5C4C3C2C1C0);
      check("t5_cnt1", word_cnt, 16'd1);
      ack();

      // 4: random gaps and ack delays, 100 words
      cnt0 = word_cnt; words = 0; cycles = 0; hold = 0;
      delay = $urandom_range(0, 5);
      while (words < 100 && cycles < 20000) begin
         s_bus.s_valid = ($urandom_range(0, 1) == 1);
         s_bus.s_data  = 8'($urandom);
         word_ack = m_valid ? (hold > delay) : ($urandom_range(0, 3) == 0);
         ackd = word_ack && m_valid;
         tick();
         cycles++;
         if (ackd) begin
            words++;
            delay = $urandom_range(0, 5);
         end
         if (m_valid) hold++; else hold = 0;
      end
      word_ack = 1'b0; s_bus.s_valid = 1'b0;
      check("t4_done", words, 100);
      check("t4_cnt", word_cnt - cnt0, 16'd100);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
